// File: rtl/raster_scan.sv
// raster_scan: walks the clamped screen-space bounding box of one triangle in
// row-major order and streams one candidate pixel coordinate per beat.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready job handshake (box, plane coefficients, flat color)
//   xmin..ymax        inclusive bounding box, unsigned
//   bounds_in         9 plane coefficients, entry [i][j] at (3i+j)*COORD_WIDTH
//   color_in          flat color
//   out_valid/out_ready pixel beat handshake
//   x, y              current pixel coordinate
//   bounds_out        job coefficients held for the whole scan
//   color_out         job color held for the whole scan
//   out_last          current beat is the final pixel of the job
//   done              one-cycle pulse after the job completes
//
// state | meaning
// IDLE  | waiting for a job, in_ready high
// SCAN  | presenting pixel beats
// DONE  | one-cycle completion pulse
module raster_scan #(
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COORD_WIDTH-1:0]   xmin,
  input  logic [COORD_WIDTH-1:0]   xmax,
  input  logic [COORD_WIDTH-1:0]   ymin,
  input  logic [COORD_WIDTH-1:0]   ymax,
  input  logic [9*COORD_WIDTH-1:0] bounds_in,
  input  logic [COLOR_WIDTH-1:0]   color_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COORD_WIDTH-1:0]   x,
  output logic [COORD_WIDTH-1:0]   y,
  output logic [9*COORD_WIDTH-1:0] bounds_out,
  output logic [COLOR_WIDTH-1:0]   color_out,
  output logic                     out_last,
  output logic                     done
);

  localparam logic [COORD_WIDTH-1:0] X_LIM = COORD_WIDTH'(SCREEN_W - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LIM = COORD_WIDTH'(SCREEN_H - 1);
  localparam logic [COORD_WIDTH-1:0] ONE   = COORD_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state_q;
  logic [COORD_WIDTH-1:0]   x_q, y_q, xmin_q, xmax_q, ymax_q;
  logic [9*COORD_WIDTH-1:0] bounds_q;
  logic [COLOR_WIDTH-1:0]   color_q;

  logic [COORD_WIDTH-1:0]   xmax_c, ymax_c;
  logic                     at_xend, at_yend;

  // Only the upper edges are clamped; the counters then never pass the screen
  // limit, so the increments below cannot wrap.
  assign xmax_c  = (xmax > X_LIM) ? X_LIM : xmax;
  assign ymax_c  = (ymax > Y_LIM) ? Y_LIM : ymax;
  assign at_xend = (x_q == xmax_q);
  assign at_yend = (y_q == ymax_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
      bounds_q <= '0;
      color_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q      <= xmin;
            y_q      <= ymin;
            xmin_q   <= xmin;
            xmax_q   <= xmax_c;
            ymax_q   <= ymax_c;
            bounds_q <= bounds_in;
            color_q  <= color_in;
            state_q  <= ((xmin > xmax_c) || (ymin > ymax_c)) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (at_xend) begin
              if (at_yend) begin
                state_q <= DONE;
              end else begin
                x_q <= xmin_q;
                y_q <= y_q + ONE;
              end
            end else begin
              x_q <= x_q + ONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status outputs decode the state register directly so that reset clears
  // out_valid without waiting for a clock edge.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == SCAN);
  assign done       = (state_q == DONE);
  assign out_last   = (state_q == SCAN) && at_xend && at_yend;
  assign x          = x_q;
  assign y          = y_q;
  assign bounds_out = bounds_q;
  assign color_out  = color_q;

endmodule

// File: tb/tb_raster_scan.sv
module tb_raster_scan;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  xmin, xmax, ymin, ymax;
  logic [143:0] bounds_in;
  logic [15:0]  color_in;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  x, y;
  logic [143:0] bounds_out;
  logic [15:0]  color_out;
  logic         out_last;
  logic         done;

  int total = 0;
  int bad   = 0;

  raster_scan #(.COORD_WIDTH(16), .COLOR_WIDTH(16), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .bounds_in(bounds_in), .color_in(color_in),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y),
    .bounds_out(bounds_out), .color_out(color_out),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, x1, y0, y1;
    int nb, fx, fy, lx, ly;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [143:0] rnd_bounds();
    logic [143:0] b;
    for (int i = 0; i < 9; i++) b[i*16 +: 16] = 16'($urandom);
    return b;
  endfunction

  // Expected beat sequence comes from plain nested loops over the clamped box.
  task automatic run_job(input int ax0, input int ax1, input int ay0, input int ay1,
                         input logic [143:0] b, input logic [15:0] c,
                         input logic [31:0] stall, input bit rnd,
                         output int nb, output int fx, output int fy,
                         output int lx, output int ly, output int dcyc);
    int qx[$];
    int qy[$];
    int xm, ym, k;
    bit fin;
    xm = (ax1 > 639) ? 639 : ax1;
    ym = (ay1 > 479) ? 479 : ay1;
    for (int yy = ay0; yy <= ym; yy++)
      for (int xx = ax0; xx <= xm; xx++) begin
        qx.push_back(xx);
        qy.push_back(yy);
      end
    nb = 0; fx = -1; fy = -1; lx = -1; ly = -1; dcyc = -1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_before_job", in_ready, 1);
    xmin = ax0[15:0]; xmax = ax1[15:0]; ymin = ay0[15:0]; ymax = ay1[15:0];
    bounds_in = b; color_in = c;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    fin = 1'b0;
    for (k = 1; k <= 5000 && !fin; k++) begin
      @(negedge clk);
      if (qx.size() > 0) begin
        chk("out_valid", out_valid, 1);
        chk("x", x, 144'(qx[0]));
        chk("y", y, 144'(qy[0]));
        chk("out_last", out_last, (qx.size() == 1));
        chk("bounds_out", bounds_out, b);
        chk("color_out", color_out, c);
        chk("done_early", done, 0);
        chk("in_ready_busy", in_ready, 0);
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(k < 32 && stall[k]);
        // Upstream chatter while busy must be ignored.
        in_valid = 1'($urandom_range(0, 1));
        bounds_in = rnd_bounds();
        color_in = 16'($urandom);
        xmin = 16'($urandom_range(0, 3));
        if (out_ready) begin
          if (nb == 0) begin fx = qx[0]; fy = qy[0]; end
          lx = qx[0]; ly = qy[0];
          nb++;
          void'(qx.pop_front());
          void'(qy.pop_front());
        end
      end else begin
        chk("done_pulse", done, 1);
        chk("out_valid_done", out_valid, 0);
        chk("bounds_out_done", bounds_out, b);
        chk("color_out_done", color_out, c);
        dcyc = k;
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        fin = 1'b1;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("in_ready_after_done", in_ready, 1);
    chk("done_one_cycle", done, 0);
    chk("out_valid_idle", out_valid, 0);
  endtask

  initial begin
    int nb, fx, fy, lx, ly, dc, x0, x1, y0, y1;
    logic [143:0] b1, b2;

    vecs[0] = '{2, 3, 5, 6, 4, 2, 5, 3, 6};
    vecs[1] = '{5, 4, 0, 0, 0, -1, -1, -1, -1};
    vecs[2] = '{638, 700, 479, 900, 2, 638, 479, 639, 479};
    vecs[3] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[4] = '{10, 12, 20, 20, 3, 10, 20, 12, 20};
    vecs[5] = '{0, 65535, 479, 479, 640, 0, 479, 639, 479};
    vecs[6] = '{0, 1, 480, 500, 0, -1, -1, -1, -1};
    vecs[7] = '{100, 100, 7, 9, 3, 100, 7, 100, 9};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    xmin = '0; xmax = '0; ymin = '0; ymax = '0; bounds_in = '0; color_in = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_bounds", bounds_out, 0);
    chk("rst_color", color_out, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, rnd_bounds(), 16'($urandom),
              32'h0, 1'b0, nb, fx, fy, lx, ly, dc);
      chk($sformatf("vec%0d_beats", i), 144'(nb), 144'(vecs[i].nb));
      chk($sformatf("vec%0d_first_x", i), 144'(fx), 144'(vecs[i].fx));
      chk($sformatf("vec%0d_first_y", i), 144'(fy), 144'(vecs[i].fy));
      chk($sformatf("vec%0d_last_x", i), 144'(lx), 144'(vecs[i].lx));
      chk($sformatf("vec%0d_last_y", i), 144'(ly), 144'(vecs[i].ly));
      chk($sformatf("vec%0d_done_cycle", i), 144'(dc), 144'(vecs[i].nb + 1));
    end

    // Stall on cycles t+2 and t+3: (3,5) held three cycles, done at t+7.
    run_job(2, 3, 5, 6, rnd_bounds(), 16'h1234, 32'h0000_000C, 1'b0, nb, fx, fy, lx, ly, dc);
    chk("stall_beats", 144'(nb), 4);
    chk("stall_done_cycle", 144'(dc), 7);

    // Back-to-back jobs with distinct payloads.
    b1 = rnd_bounds();
    b2 = ~b1;
    run_job(4, 6, 1, 2, b1, 16'hAAAA, 32'h0, 1'b0, nb, fx, fy, lx, ly, dc);
    chk("b2b_job1_beats", 144'(nb), 6);
    run_job(7, 7, 3, 4, b2, 16'h5555, 32'h0, 1'b0, nb, fx, fy, lx, ly, dc);
    chk("b2b_job2_beats", 144'(nb), 2);

    // Reset after 3 beats of a 4x4 job.
    xmin = 16'd0; xmax = 16'd3; ymin = 16'd0; ymax = 16'd3;
    bounds_in = rnd_bounds(); color_in = 16'hBEEF;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_mid_valid", out_valid, 1);
    chk("abort_mid_x", x, 3);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_last", out_last, 0);
    chk("abort_x", x, 0);
    chk("abort_bounds", bounds_out, 0);
    chk("abort_color", color_out, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_job(9, 9, 9, 9, rnd_bounds(), 16'h0F0F, 32'h0, 1'b0, nb, fx, fy, lx, ly, dc);
    chk("post_abort_beats", 144'(nb), 1);
    chk("post_abort_done_cycle", 144'(dc), 2);

    // Randomized jobs with random backpressure, checked against the loop model.
    for (int i = 0; i < 25; i++) begin
      x0 = $urandom_range(0, 645);
      x1 = x0 + $urandom_range(0, 5);
      y0 = $urandom_range(0, 484);
      y1 = y0 + $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0 && x0 > 0) x1 = x0 - 1;
      run_job(x0, x1, y0, y1, rnd_bounds(), 16'($urandom), 32'h0, 1'b1, nb, fx, fy, lx, ly, dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/raster_scan.md
# raster_scan

Rasterizer front stage that walks the screen-space bounding box of one triangle in row-major order and streams one candidate pixel coordinate per cycle into the per-pixel plane-test unit. It accepts one triangle job at a time (box, three edge-plane coefficient triplets, flat color) over a valid/ready handshake. It holds the job's coefficients and color stable for the whole scan and signals completion with a one-cycle pulse.

## Interface

- COORD_WIDTH, 16, width of x/y and of each plane coefficient
- COLOR_WIDTH, 16, width of flat color
- SCREEN_W, 640, screen width in pixels; x clamped to SCREEN_W-1
- SCREEN_H, 480, screen height in pixels; y clamped to SCREEN_H-1

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  job present
- in_ready  out  1  block can accept a job
- xmin, xmax, ymin, ymax  in  COORD_WIDTH each  inclusive bounding box, unsigned
- bounds_in  in  9*COORD_WIDTH  plane coefficients; entry [i][j] at bits (3i+j)*COORD_WIDTH +: COORD_WIDTH
- color_in  in  COLOR_WIDTH  triangle flat color
- out_valid  out  1  pixel beat valid
- out_ready  in  1  downstream accepts beat
- x, y  out  COORD_WIDTH each  current pixel coordinate
- bounds_out  out  9*COORD_WIDTH  registered copy of job coefficients, same packing
- color_out  out  COLOR_WIDTH  registered copy of job color
- out_last  out  1  current beat is final pixel of job
- done  out  1  one-cycle pulse after job completes

## Operation

- States: IDLE, SCAN, DONE.
- in_ready = (state == IDLE), combinational.
- IDLE:
  - On in_valid & in_ready, register clamped box, bounds_in and color_in.
  - Clamping: xmax' = min(xmax, SCREEN_W-1); ymax' = min(ymax, SCREEN_H-1). xmin and ymin are unchanged.
  - Load x = xmin, y = ymin.
  - If xmin > xmax' or ymin > ymax', the box is empty: go to DONE. Otherwise go to SCAN.
- SCAN:
  - out_valid = 1.
  - On out_valid & out_ready:
    - If x == xmax' and y == ymax', go to DONE.
    - Else if x == xmax', set x = xmin and y = y+1.
    - Else set x = x+1.
  - Without out_ready, x, y, out_last, bounds_out and color_out hold (AXI-style: no valid drop, no data change).
- out_last = SCAN & (x == xmax') & (y == ymax').
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Comparisons are unsigned at COORD_WIDTH.
  - Counters never exceed xmax'/ymax' ≤ SCREEN-1, so no wrap.
  - xmax = 2^COORD_WIDTH-1 is legal and clamps.
- bounds_out and color_out change only on job acceptance.

## Timing

- Reset values: state IDLE, out_valid 0, out_last 0, done 0, x 0, y 0, bounds_out 0, color_out 0.
  - in_ready is 1 while reset is asserted and after it deasserts.
- Job accepted at edge t → first beat valid in cycle t+1 (latency 1).
- Throughput: one pixel per cycle while out_ready stays high.
  - A W×H box occupies W·H SCAN cycles, then 1 DONE cycle.
  - in_ready returns the cycle after done.
  - Job-to-job gap: 2 cycles (DONE, IDLE accept).
- Empty box: accepted at t, done at t+1, in_ready at t+2. No out_valid.
- Reset mid-scan aborts immediately: out_valid drops asynchronously and the job is discarded.
- in_valid while not in_ready is ignored. Upstream holds its inputs.

## Test plan

- Box x 2..3, y 5..6, out_ready=1 → beats (2,5),(3,5),(2,6),(3,6) on cycles t+1..t+4. out_last on (3,6) only. done at t+5. in_ready at t+6.
- Same box, out_ready low on cycles t+2 and t+3 → (3,5) held unchanged for 3 cycles. Total 4 beats. done delayed by 2 cycles.
- Empty box xmin=5, xmax=4 → zero beats. done at t+1.
- Box x 638..700, y 479..900 with SCREEN 640×480 → exactly (638,479),(639,479). out_last on the second.
- Reset asserted after 3 beats of a 4×4 job → out_valid 0 and state IDLE in the same cycle. A new 1×1 job then gives a single beat with out_last=1.
- Two back-to-back jobs with distinct bounds_in and color_in → bounds_out and color_out switch exactly at the first beat of job 2. Job 1 values stay constant through its last beat.
